// File: rtl/conv_pkg.sv
// Shared widths and FSM encoding for the 3x3 window sequencer.
// Latency: none (package only); backpressure: n/a.
package conv_pkg;
  localparam int PIX_W       = 8;
  localparam int KERNEL_TAPS = 9;
  localparam int WIN_W       = 72;
  localparam int NUM_LINEBUF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;
endpackage

// File: rtl/conv_window_line_buffer.sv
// One image line of storage; exposes three consecutive pixels at its read pointer.
// Latency: combinational read, write lands on the clock edge; backpressure: none, the controller gates both strobes.
module line_buffer
  import conv_pkg::*;
#(
  parameter int LINE_WIDTH = 512
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [PIX_W-1:0]     i_data,
  input  logic                 i_data_valid,
  input  logic                 i_rd_data,
  output logic [3*PIX_W-1:0]   o_data
);
  localparam int AW = $clog2(LINE_WIDTH);

  logic [PIX_W-1:0] mem [LINE_WIDTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is deliberately never cleared; only the pointers reset.
  always_ff @(posedge i_clk) begin
    if (i_data_valid) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (i_data_valid) begin
        wr_ptr <= (wr_ptr == AW'(LINE_WIDTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (i_rd_data) begin
        rd_ptr <= (rd_ptr == AW'(LINE_WIDTH - 3)) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  assign o_data = {mem[rd_ptr + AW'(2)], mem[rd_ptr + AW'(1)], mem[rd_ptr]};
endmodule

// File: rtl/conv_window_ctrl.sv
// Raster stream -> four round-robin line buffers -> 72-bit 3x3 windows, with a line-freed interrupt.
// Latency: window 1 cycle after its read strobe; backpressure: o_pixel_ready low while all four buffers hold lines.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int LINE_WIDTH = 512
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIX_W-1:0]   i_pixel_data,
  input  logic               i_pixel_data_valid,
  output logic               o_pixel_ready,
  output logic [WIN_W-1:0]   o_pixel_data,
  output logic               o_pixel_data_valid,
  output logic               o_intr
);
  localparam int AW = $clog2(LINE_WIDTH);

  state_t              state;
  state_t              state_nxt;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [1:0]          wr_sel;
  logic [1:0]          rd_sel;
  logic [2:0]          lines_filled;
  logic                ready_en;
  logic                accept;
  logic                wr_last;
  logic                rd_en;
  logic                rd_last;
  logic                rd_go;
  logic [3*PIX_W-1:0]  buf_data [NUM_LINEBUF];
  logic [WIN_W-1:0]    window;

  // ready_en keeps the write side closed for the cycle that follows reset.
  assign o_pixel_ready = ready_en && (lines_filled < 3'd4);
  assign accept        = i_pixel_data_valid && o_pixel_ready;
  assign wr_last       = accept && (wr_ptr == AW'(LINE_WIDTH - 1));
  assign rd_en         = (state == READ);
  assign rd_last       = rd_en && (rd_ptr == AW'(LINE_WIDTH - 3));
  assign rd_go         = (lines_filled >= 3'd3);

  for (genvar k = 0; k < NUM_LINEBUF; k++) begin : g_lb
    // The buffer three slots ahead of rd_sel is the one being filled, so it is not strobed.
    line_buffer #(.LINE_WIDTH(LINE_WIDTH)) u_lb (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_data       (i_pixel_data),
      .i_data_valid (accept && (wr_sel == 2'(k))),
      .i_rd_data    (rd_en && ((rd_sel + 2'd3) != 2'(k))),
      .o_data       (buf_data[k])
    );
  end

  assign window = {buf_data[rd_sel + 2'd2], buf_data[rd_sel + 2'd1], buf_data[rd_sel]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_go)   state_nxt = READ;
      READ:    if (rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      ready_en           <= 1'b0;
      wr_ptr             <= '0;
      wr_sel             <= '0;
      rd_ptr             <= '0;
      rd_sel             <= '0;
      lines_filled       <= '0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_intr             <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (accept) begin
        wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
      end
      if (wr_last) begin
        wr_sel <= wr_sel + 2'd1;
      end
      if (rd_en) begin
        rd_ptr       <= rd_last ? '0 : rd_ptr + 1'b1;
        o_pixel_data <= window;
      end
      if (rd_last) begin
        rd_sel <= rd_sel + 2'd1;
      end
      case ({wr_last, rd_last})
        2'b10:   lines_filled <= lines_filled + 3'd1;
        2'b01:   lines_filled <= lines_filled - 3'd1;
        default: lines_filled <= lines_filled;
      endcase
      o_pixel_data_valid <= rd_en;
      o_intr             <= rd_last;
    end
  end

  assert property (@(posedge i_clk) disable iff (i_rst)
    !(wr_last && !rd_last && (lines_filled == 3'd4)));
  assert property (@(posedge i_clk) disable iff (i_rst)
    !(rd_last && !wr_last && (lines_filled == 3'd0)));
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl with LINE_WIDTH=8 and a golden 3x3 window model.
module tb_conv_window_ctrl;
  import conv_pkg::*;

  localparam int LW = 8;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_pixel_data;
  logic        i_pixel_data_valid;
  logic        o_pixel_ready;
  logic [71:0] o_pixel_data;
  logic        o_pixel_data_valid;
  logic        o_intr;

  int          checks = 0;
  int          failures = 0;
  int          win_cnt = 0;
  int          intr_cnt = 0;
  int          rd_line = 0;
  int          rd_col = 0;
  int          stalls = 0;
  logic [7:0]  base = 8'h00;
  logic [23:0] top_l1 = '0;
  logic [71:0] first_fresh = '0;
  logic [71:0] exp_w;
  logic        fresh_seen = 1'b0;
  logic        chk_rise = 1'b0;
  logic        prev_rdy = 1'b0;

  conv_window_ctrl #(.LINE_WIDTH(LW)) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_pixel_data       (i_pixel_data),
    .i_pixel_data_valid (i_pixel_data_valid),
    .o_pixel_ready      (o_pixel_ready),
    .o_pixel_data       (o_pixel_data),
    .o_pixel_data_valid (o_pixel_data_valid),
    .o_intr             (o_intr)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] pix(int line, int col);
    return 8'(int'(base) + line * 16 + col);
  endfunction

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Golden model: every window is rebuilt from the pixel formula; o_intr must close a 6-window line.
  always @(negedge i_clk) begin
    if (i_rst) begin
      rd_line = 0;
      rd_col  = 0;
    end else begin
      if (o_pixel_data_valid) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_w[8*(3*r+c) +: 8] = pix(rd_line + r, rd_col + c);
        checks++;
        assert (o_pixel_data === exp_w) else begin
          failures++;
          $error("FAIL window line=%0d col=%0d observed=%h expected=%h", rd_line, rd_col, o_pixel_data, exp_w);
        end
        if (rd_line == 1 && rd_col == 0 && base == 8'h00) top_l1 = o_pixel_data[23:0];
        if (!fresh_seen && base == 8'h80) begin
          first_fresh = o_pixel_data;
          fresh_seen  = 1'b1;
        end
        win_cnt++;
        rd_col++;
      end
      if (o_intr) begin
        checks++;
        assert (rd_col == 6) else begin
          failures++;
          $error("FAIL intr_spacing observed=%0d expected=6", rd_col);
        end
        intr_cnt++;
        rd_line++;
        rd_col = 0;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (chk_rise && !prev_rdy && o_pixel_ready)
      chk("ready_rise_with_intr", 72'(o_intr), 72'(1));
    prev_rdy = o_pixel_ready;
  endtask

  task automatic push(input logic [7:0] d);
    int   n;
    logic r;
    logic done;
    n    = 0;
    done = 1'b0;
    i_pixel_data       = d;
    i_pixel_data_valid = 1'b1;
    while (!done) begin
      r = o_pixel_ready;
      tick();
      if (r) begin
        done = 1'b1;
      end else begin
        stalls++;
        n++;
        if (n > 100) begin
          failures++;
          $display("FAIL push_timeout observed=stalled expected=accept");
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $fatal(1, "push timeout");
        end
      end
    end
  endtask

  task automatic push_line(input int line);
    for (int c = 0; c < LW; c++) push(pix(line, c));
  endtask

  task automatic wait_intr(input int target, input int budget);
    int n;
    n = 0;
    while (intr_cnt < target && n < budget) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) tick();
    chk("intr_count", 72'(intr_cnt), 72'(target));
  endtask

  initial begin
    int w0;
    int i0;
    int n;
    i_rst = 1'b1;
    i_pixel_data = '0;
    i_pixel_data_valid = 1'b0;
    tick();
    tick();
    chk("rst_ready", 72'(o_pixel_ready), 72'(0));
    chk("rst_valid", 72'(o_pixel_data_valid), 72'(0));
    chk("rst_intr", 72'(o_intr), 72'(0));
    chk("rst_data", o_pixel_data, 72'(0));
    chk("rst_state", 72'(dut.state), 72'(IDLE));
    chk("rst_filled", 72'(dut.lines_filled), 72'(0));
    i_rst = 1'b0;
    tick();
    chk("ready_after_reset", 72'(o_pixel_ready), 72'(1));

    // Two lines: no windows, no interrupt, never stalled.
    push_line(0);
    push_line(1);
    i_pixel_data_valid = 1'b0;
    tick();
    chk("two_lines_no_stall", 72'(stalls), 72'(0));
    chk("two_lines_windows", 72'(win_cnt), 72'(0));
    chk("two_lines_intr", 72'(intr_cnt), 72'(0));
    chk("two_lines_filled", 72'(dut.lines_filled), 72'(2));

    // Third line starts reading.
    push_line(2);
    i_pixel_data_valid = 1'b0;
    chk("line2_state_idle", 72'(dut.state), 72'(IDLE));
    chk("line2_filled", 72'(dut.lines_filled), 72'(3));
    tick();
    chk("line2_state_read", 72'(dut.state), 72'(READ));
    tick();
    chk("first_valid", 72'(o_pixel_data_valid), 72'(1));
    chk("first_window", o_pixel_data, 72'h22_21_20_12_11_10_02_01_00);
    wait_intr(1, 30);
    chk("line2_windows", 72'(win_cnt), 72'(6));
    chk("line2_filled_after", 72'(dut.lines_filled), 72'(2));

    // Hold off reads until all four buffers fill, then let the stalled writer resume.
    force dut.rd_go = 1'b0;
    push_line(3);
    push_line(4);
    i_pixel_data = pix(5, 0);
    chk("full_ready_low", 72'(o_pixel_ready), 72'(0));
    chk("full_filled", 72'(dut.lines_filled), 72'(4));
    tick();
    tick();
    chk("full_no_write", 72'(dut.wr_ptr), 72'(0));
    chk("full_still_filled", 72'(dut.lines_filled), 72'(4));
    chk_rise = 1'b1;
    release dut.rd_go;
    stalls = 0;
    push_line(5);
    push_line(6);
    push_line(7);
    i_pixel_data_valid = 1'b0;
    chk("full_stalled", 72'(stalls > 0), 72'(1));
    wait_intr(6, 100);
    chk("full_windows", 72'(win_cnt), 72'(36));
    chk("line1_top_row", 72'(top_l1), 72'h12_11_10);
    chk("full_filled_after", 72'(dut.lines_filled), 72'(2));

    // Delay one read start so write-line and read-line completion share an edge.
    push_line(8);
    force dut.rd_go = 1'b0;
    for (int c = 0; c < LW; c++) begin
      push(pix(9, c));
      if (c == 0) release dut.rd_go;
    end
    i_pixel_data_valid = 1'b0;
    chk("coincide_intr", 72'(o_intr), 72'(1));
    chk("coincide_filled", 72'(dut.lines_filled), 72'(3));
    chk("coincide_rd_sel", 72'(dut.rd_sel), 72'(3));
    wait_intr(8, 60);
    chk("coincide_windows", 72'(win_cnt), 72'(48));
    chk("wrap_rd_sel", 72'(dut.rd_sel), 72'(0));
    chk("coincide_filled_after", 72'(dut.lines_filled), 72'(2));

    // Reset in the middle of a read line.
    push_line(10);
    i_pixel_data_valid = 1'b0;
    n = 0;
    while (!(dut.state == READ && dut.rd_ptr == 3) && n < 20) begin
      tick();
      n++;
    end
    chk("reach_rd_ptr3", 72'(dut.rd_ptr), 72'(3));
    chk_rise = 1'b0;
    i_rst = 1'b1;
    tick();
    chk("midrst_data", o_pixel_data, 72'(0));
    chk("midrst_valid", 72'(o_pixel_data_valid), 72'(0));
    chk("midrst_intr", 72'(o_intr), 72'(0));
    chk("midrst_ready", 72'(o_pixel_ready), 72'(0));
    chk("midrst_state", 72'(dut.state), 72'(IDLE));
    chk("midrst_filled", 72'(dut.lines_filled), 72'(0));
    base = 8'h80;
    i_rst = 1'b0;
    tick();
    chk_rise = 1'b1;
    w0 = win_cnt;
    i0 = intr_cnt;

    // Twenty-line continuous stream from fresh state.
    for (int l = 0; l < 20; l++) push_line(l);
    i_pixel_data_valid = 1'b0;
    wait_intr(i0 + 18, 400);
    chk("stream_windows", 72'(win_cnt - w0), 72'(108));
    chk("fresh_first_window", first_fresh, 72'hA2_A1_A0_92_91_90_82_81_80);
    chk("stream_filled", 72'(dut.lines_filled), 72'(2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
